uart_tx_arbiter: RTL and testbench

- Shares the single UART byte transmitter between up to N message sources: debug signal dump, ping/OK responder, register-read replies and similar.
- Requesters present byte streams with valid/last/ready. The arbiter grants one requester at a time, round-robin, and holds the grant until that requester's last byte has been transmitted.
- Sequences the transmitter through a tx_start/tx_done handshake.
- A stall watchdog aborts a message whose owner stops supplying bytes.

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between N_REQ message sources.
// Optional source-tag prefix byte enabled by defining UART_TX_ARB_TAG_EN.
module uart_tx_arbiter #(
    parameter int          N_REQ       = 4,
    parameter int          IDX_W       = 2,
    parameter logic [15:0] STALL_LIMIT = 16'd8680
`ifdef UART_TX_ARB_TAG_EN
    ,
    parameter logic [7:0]  TAG_BASE    = 8'h10
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               tx_start,
    output logic [7:0]         tx_byte,
    input  logic               tx_done,
    output logic               busy,
    output logic               abort,
    output logic [IDX_W-1:0]   abort_id,
    output logic [2:0]         state_dbg
);

    // Handshake: a byte moves from requester g when req_valid[g] && req_ready[g]
    // are both high at a rising clk edge; ready is only ever offered in FETCH.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_TAG   = 3'd4
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;
    logic [15:0]      stall_cnt;
    logic             last_flag;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic             accept;
    logic [16:0]      stall_inc;
    logic             stall_hit;

    function automatic logic [IDX_W-1:0] add_mod(input logic [IDX_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // Walk downward so the lowest offset from ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[add_mod(ptr, i)]) begin
                pick_vld = 1'b1;
                pick_idx = add_mod(ptr, i);
            end
        end
    end

    assign req_ready = (state == S_FETCH) ? (grant & req_valid) : '0;
    assign accept    = |req_ready;
    assign stall_inc = {1'b0, stall_cnt} + 17'd1;
    assign stall_hit = (stall_inc >= {1'b0, STALL_LIMIT});
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            gidx      <= '0;
            stall_cnt <= '0;
            last_flag <= 1'b0;
            grant     <= '0;
            tx_start  <= 1'b0;
            tx_byte   <= 8'h00;
            abort     <= 1'b0;
            abort_id  <= '0;
        end else begin
            tx_start <= 1'b0;
            abort    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        gidx      <= pick_idx;
                        stall_cnt <= '0;
`ifdef UART_TX_ARB_TAG_EN
                        state     <= S_TAG;
`else
                        state     <= S_FETCH;
`endif
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                S_TAG: begin
                    tx_byte   <= TAG_BASE + 8'(gidx);
                    last_flag <= 1'b0;
                    tx_start  <= 1'b1;
                    state     <= S_START;
                end
`endif
                S_FETCH: begin
                    if (accept) begin
                        tx_byte   <= req_data[gidx*8 +: 8];
                        last_flag <= req_last[gidx];
                        stall_cnt <= '0;
                        tx_start  <= 1'b1;
                        state     <= S_START;
                    end else if (stall_hit) begin
                        // Owner went silent: drop the message without any terminator.
                        abort     <= 1'b1;
                        abort_id  <= gidx;
                        grant     <= '0;
                        ptr       <= add_mod(gidx, 1);
                        stall_cnt <= '0;
                        state     <= S_IDLE;
                    end else if (stall_cnt != 16'hFFFF) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        if (last_flag) begin
                            grant <= '0;
                            ptr   <= add_mod(gidx, 1);
                            state <= S_IDLE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_uart_tx_arbiter;

    localparam int N_REQ       = 4;
    localparam int IDX_W       = 2;
    localparam int STALL_LIMIT = 8680;

    logic               clk;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   grant;
    logic               tx_start;
    logic [7:0]         tx_byte;
    logic               tx_done;
    logic               busy;
    logic               abort;
    logic [IDX_W-1:0]   abort_id;
    logic [2:0]         state_dbg;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W),
        .STALL_LIMIT(16'(STALL_LIMIT))
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .grant(grant),
        .tx_start(tx_start),
        .tx_byte(tx_byte),
        .tx_done(tx_done),
        .busy(busy),
        .abort(abort),
        .abort_id(abort_id),
        .state_dbg(state_dbg)
    );

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp);
        end
    endtask

    // driver tasks
    task automatic present(input int r, input logic [7:0] d, input logic lst);
        req_valid[r]       = 1'b1;
        req_data[8*r +: 8] = d;
        req_last[r]        = lst;
    endtask

    // Called on the negedge right after tx_start; returns on the negedge after tx_done.
    task automatic done_after(input int dly);
        @(negedge clk);
        chk("tx_start width", 32'(tx_start), 32'd0);
        chk("ready in WAIT", 32'(req_ready), 32'd0);
        repeat (dly - 2) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Called on a negedge in FETCH with requester r owning the bus.
    task automatic byte_xfer(input int r, input logic [7:0] d, input logic lst, input int dly);
        logic [7:0] e;
        present(r, d, lst);
        #1;
        chk("ready in FETCH", 32'(req_ready), 32'd1 << r);
        @(negedge clk);
        req_valid[r] = 1'b0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = d;
        chk("tx_start", 32'(tx_start), 32'd1);
        chk("tx_byte", 32'(tx_byte), 32'(e));
        chk("grant held", 32'(grant), 32'd1 << r);
        done_after(dly);
    endtask

    initial begin
        int   cnt;
        logic seen;
        logic flag;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_done   = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst grant", 32'(grant), 32'd0);
        chk("rst tx_start", 32'(tx_start), 32'd0);
        chk("rst tx_byte", 32'(tx_byte), 32'd0);
        chk("rst abort", 32'(abort), 32'd0);
        chk("rst abort_id", 32'(abort_id), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef UART_TX_ARB_TAG_EN
        // Tag prefix: requester 1 sends one byte, preceded by TAG_BASE+1.
        present(1, 8'h02, 1'b1);
        @(negedge clk);
        chk("tag grant", 32'(grant), 32'b0010);
        chk("tag no ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("tag tx_start", 32'(tx_start), 32'd1);
        chk("tag byte", 32'(tx_byte), 32'h11);
        done_after(20);
        byte_xfer(1, 8'h02, 1'b1, 20);
        chk("tag idle busy", 32'(busy), 32'd0);
        chk("tag idle grant", 32'(grant), 32'd0);
`else
        // Single message from requester 1 with 868-cycle byte times.
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        present(1, 8'h01, 1'b0);
        @(negedge clk);
        chk("msg grant", 32'(grant), 32'b0010);
        chk("msg busy", 32'(busy), 32'd1);
        byte_xfer(1, 8'h01, 1'b0, 868);
        byte_xfer(1, 8'hAA, 1'b0, 868);
        byte_xfer(1, 8'h55, 1'b1, 868);
        chk("msg end busy", 32'(busy), 32'd0);
        chk("msg end grant", 32'(grant), 32'd0);
        chk("msg exp_q drained", 32'(exp_q.size()), 32'd0);

        // ptr is now 2: requesters 1 and 3 compete, 3 wins, then wrap to 1.
        present(1, 8'h11, 1'b1);
        present(3, 8'h33, 1'b1);
        @(negedge clk);
        chk("ptr2 grant", 32'(grant), 32'b1000);
        byte_xfer(3, 8'h33, 1'b1, 20);
        @(negedge clk);
        chk("wrap grant", 32'(grant), 32'b0010);
        byte_xfer(1, 8'h11, 1'b1, 20);

        // Reset while in WAIT.
        present(2, 8'h77, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre-rst WAIT", 32'(state_dbg), 32'd3);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("mid rst grant", 32'(grant), 32'd0);
        chk("mid rst tx_byte", 32'(tx_byte), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst tx_start", 32'(tx_start), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        flag  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            flag = flag | tx_start | busy;
        end
        chk("post rst quiet", 32'(flag), 32'd0);

        // Round-robin with ptr=0: requesters 0 and 2, then 0 again.
        present(0, 8'hA0, 1'b1);
        present(2, 8'hA2, 1'b1);
        @(negedge clk);
        chk("rr first", 32'(grant), 32'b0001);
        byte_xfer(0, 8'hA0, 1'b1, 20);
        present(0, 8'hB0, 1'b1);
        @(negedge clk);
        chk("rr second", 32'(grant), 32'b0100);
        byte_xfer(2, 8'hA2, 1'b1, 20);
        @(negedge clk);
        chk("rr third", 32'(grant), 32'b0001);
        byte_xfer(0, 8'hB0, 1'b1, 20);

        // No preemption: requester 3 waits out a 4-byte message from requester 0.
        present(0, 8'hC0, 1'b0);
        @(negedge clk);
        chk("np grant", 32'(grant), 32'b0001);
        present(3, 8'hD3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            byte_xfer(0, 8'hC0 + 8'(k), (k == 3), 20);
        end
        chk("np idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("np next grant", 32'(grant), 32'b1000);
        byte_xfer(3, 8'hD3, 1'b1, 20);

        // Watchdog: one non-last byte, then silence.
        present(2, 8'hE2, 1'b0);
        @(negedge clk);
        chk("wd grant", 32'(grant), 32'b0100);
        byte_xfer(2, 8'hE2, 1'b0, 20);
        cnt  = 0;
        seen = 1'b0;
        flag = 1'b0;
        while (!seen && cnt < STALL_LIMIT + 200) begin
            @(negedge clk);
            cnt++;
            flag = flag | tx_start;
            if (abort) seen = 1'b1;
        end
        chk("wd latency", 32'(cnt), 32'(STALL_LIMIT));
        chk("wd abort_id", 32'(abort_id), 32'd2);
        chk("wd grant clr", 32'(grant), 32'd0);
        chk("wd busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("wd abort pulse", 32'(abort), 32'd0);
        chk("wd id held", 32'(abort_id), 32'd2);
        repeat (20) begin
            @(negedge clk);
            flag = flag | tx_start;
        end
        chk("wd no tx_start", 32'(flag), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
